// File: rtl/ref_row_fetcher_pkg.sv
// Shared constants for the reference-window row fetcher: pixel/row geometry,
// filter-tap margin and FSM state encoding.
package ref_row_fetcher_pkg;
  localparam int PIX_W      = 8;
  localparam int ROW_PIX    = 15;
  localparam int NUM_ROWS   = 15;
  localparam int TAP_MARGIN = 3;
  localparam int ROW_W      = PIX_W * ROW_PIX;
  localparam int WORD_W     = 64;
  localparam int WIN_W      = 3 * WORD_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;
endpackage

// File: rtl/ref_row_fetcher_row_aligner.sv
// Funnel-shifts three memory words down to one 15-pixel row by xs[2:0].
// With REF_ROW_FETCHER_EDGE_PAD_EN, pixels left/right of the frame replicate the edge column.
module ref_row_fetcher_row_aligner
  import ref_row_fetcher_pkg::*;
#(
  parameter int FRAME_W_WORDS = 240,
  parameter int X_W           = 11
) (
  input  logic [WIN_W-1:0]     win,
  input  logic signed [X_W:0]  xs,
  output logic [ROW_W-1:0]     row
);
  logic [WIN_W-1:0] shifted;
  assign shifted = win >> (PIX_W * int'(xs[2:0]));

`ifdef REF_ROW_FETCHER_EDGE_PAD_EN
  localparam int MAX_COL = 8 * FRAME_W_WORDS - 1;
  // Out-of-frame columns only occur when the words were clamped, so word 0
  // byte 0 holds column 0 and word 2 byte 7 holds the last column.
  for (genvar i = 0; i < ROW_PIX; i++) begin : g_pix
    logic signed [X_W+1:0] col;
    assign col = $signed({xs[X_W], xs}) + $signed((X_W+2)'(i));
    always_comb begin
      row[i*PIX_W +: PIX_W] = shifted[i*PIX_W +: PIX_W];
      if (col[X_W+1])
        row[i*PIX_W +: PIX_W] = win[PIX_W-1:0];
      else if (col > $signed((X_W+2)'(MAX_COL)))
        row[i*PIX_W +: PIX_W] = win[WIN_W-1 -: PIX_W];
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{xs[X_W:3], 32'(FRAME_W_WORDS)};
  for (genvar i = 0; i < ROW_PIX; i++) begin : g_pix
    assign row[i*PIX_W +: PIX_W] = shifted[i*PIX_W +: PIX_W];
  end
`endif
endmodule

// File: rtl/ref_row_fetcher.sv
// Reads the 15x15 integer-pixel reference window around (x0,y0) and streams it
// one row per valid/ready transfer. Optional macro: REF_ROW_FETCHER_EDGE_PAD_EN.
module ref_row_fetcher
  import ref_row_fetcher_pkg::*;
#(
  parameter int FRAME_W_WORDS = 240,
  parameter int FRAME_H       = 1080,
  parameter int ADDR_W        = 18,
  parameter int X_W           = 11,
  parameter int Y_W           = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic [ROW_W-1:0]    row_out,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [3:0]          row_idx
);
  logic [1:0]        state;
  logic [1:0]        k;
  logic [3:0]        r;
  logic [X_W-1:0]    x0_q;
  logic [Y_W-1:0]    y0_q;
  logic [WORD_W-1:0] w0, w1;
  logic [ROW_W-1:0]  row_asm;

  logic signed [X_W:0]   xs, wcol, wcol_c;
  logic signed [Y_W:0]   ys;
  logic signed [Y_W+1:0] line_s, line_c;

  assign xs     = $signed({1'b0, x0_q}) - $signed((X_W+1)'(TAP_MARGIN));
  assign ys     = $signed({1'b0, y0_q}) - $signed((Y_W+1)'(TAP_MARGIN));
  assign wcol   = (xs >>> 3) + $signed({{(X_W-1){1'b0}}, k});
  assign line_s = $signed({ys[Y_W], ys}) + $signed({{(Y_W-2){1'b0}}, r});

`ifdef REF_ROW_FETCHER_EDGE_PAD_EN
  always_comb begin
    line_c = line_s;
    if (line_s[Y_W+1])                            line_c = '0;
    else if (line_s > $signed((Y_W+2)'(FRAME_H-1))) line_c = (Y_W+2)'(FRAME_H-1);
    wcol_c = wcol;
    if (wcol[X_W])                                      wcol_c = '0;
    else if (wcol > $signed((X_W+1)'(FRAME_W_WORDS-1))) wcol_c = (X_W+1)'(FRAME_W_WORDS-1);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(FRAME_H);
  assign line_c = line_s;
  assign wcol_c = wcol;
`endif

  assign busy      = (state != ST_IDLE);
  assign mem_rd_en = (state == ST_REQ);
  assign row_valid = (state == ST_OUT);
  assign row_idx   = r;
  assign mem_addr  = mem_rd_en ?
                     ADDR_W'(line_c) * ADDR_W'(FRAME_W_WORDS) + ADDR_W'(wcol_c) : '0;

  // Word k=2 is not registered: it is consumed straight off the bus in LAST.
  ref_row_fetcher_row_aligner #(
    .FRAME_W_WORDS(FRAME_W_WORDS),
    .X_W          (X_W)
  ) u_row_aligner (
    .win(({mem_rdata, w1, w0})),
    .xs (xs),
    .row(row_asm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      r       <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w0      <= '0;
      w1      <= '0;
      row_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          x0_q  <= x0;
          y0_q  <= y0;
          k     <= '0;
          r     <= '0;
          state <= ST_REQ;
        end
        ST_REQ: begin
          // Read data trails its strobe by one cycle.
          if (k == 2'd1) w0 <= mem_rdata;
          if (k == 2'd2) begin
            w1    <= mem_rdata;
            k     <= '0;
            state <= ST_LAST;
          end else begin
            k <= k + 2'd1;
          end
        end
        ST_LAST: begin
          row_out <= row_asm;
          state   <= ST_OUT;
        end
        default: if (row_ready) begin
          if (r == 4'(NUM_ROWS-1)) begin
            r     <= '0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            r     <= r + 4'd1;
            state <= ST_REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ref_row_fetcher.sv
// Randomized self-checking bench for ref_row_fetcher against a pixel-level window model.
module tb_ref_row_fetcher;
  import ref_row_fetcher_pkg::*;
  localparam int FW = 4, FH = 64, AW = 18, XW = 11, YW = 11;

  logic clk = 1'b0, rst, start, row_ready;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic busy, done, mem_rd_en, row_valid;
  logic [AW-1:0] mem_addr;
  logic [63:0] mem_rdata;
  logic [ROW_W-1:0] row_out;
  logic [3:0] row_idx;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  ref_row_fetcher #(.FRAME_W_WORDS(FW), .FRAME_H(FH), .ADDR_W(AW), .X_W(XW), .Y_W(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .row_out(row_out),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Frame content: pixel(x,y) = (x + 32*y) & 0xFF, 8 pixels per word.
  function automatic logic [63:0] word_at(int a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'((8*(a % FW) + j + 32*(a / FW)) & 255);
    return w;
  endfunction

  function automatic int pix(int x, int y);
`ifdef REF_ROW_FETCHER_EDGE_PAD_EN
    x = clampi(x, 0, 8*FW-1);
    y = clampi(y, 0, FH-1);
`endif
    return (x + 32*y) & 255;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(int x, int y, int r);
    logic [ROW_W-1:0] v;
    for (int i = 0; i < ROW_PIX; i++) v[8*i +: 8] = 8'(pix(x - 3 + i, y - 3 + r));
    return v;
  endfunction

  // n-th read strobe of a block: row n/3, word n%3 of that row's window.
  function automatic int exp_addr(int x, int y, int n);
    int xs, wb, ln, col;
    xs  = x - 3;
    wb  = (xs >= 0) ? xs / 8 : -((7 - xs) / 8);
    ln  = y - 3 + n / 3;
    col = wb + n % 3;
`ifdef REF_ROW_FETCHER_EDGE_PAD_EN
    ln  = clampi(ln, 0, FH-1);
    col = clampi(col, 0, FW-1);
`endif
    return ln * FW + col;
  endfunction

  always @(posedge clk)
    mem_rdata <= mem_rd_en ? word_at(int'(mem_addr)) : {$urandom, $urandom};

  // mode: 0 ready always, 1 random ready, 2 start re-pulsed while busy, 3 stall row 2 for 10 cycles
  task automatic run_block(input int x, input int y, input int mode, input bit timing);
    int nrows = 0, nrd = 0, stall = 0;
    bit got_done = 0, hold = 0;
    logic [ROW_W-1:0] prev_row;
    logic [3:0] prev_idx;
    @(posedge clk); #1;
    x0 = XW'(x); y0 = YW'(y); start = 1'b1; row_ready = 1'b1;
    for (int c = 1; c < 400 && !got_done; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 2 && c == 20) begin start = 1'b1; x0 = XW'(x + 8); y0 = YW'(y + 1); end
      case (mode)
        1: row_ready = ($urandom_range(0, 3) != 0);
        3: begin
          row_ready = !(row_valid && row_idx == 4'd2 && stall < 10);
          if (!row_ready) stall++;
        end
        default: row_ready = 1'b1;
      endcase
      #1;
      if (timing) begin
        if (c <= 3) chk("rd_en_req", mem_rd_en, 1);
        if (c == 4) chk("rd_en_last", mem_rd_en, 0);
        if (c == 4) chk("valid_early", row_valid, 0);
        if (c == 5) chk("valid_t5", row_valid, 1);
      end
      if (hold) begin
        chk("hold_valid", row_valid, 1);
        chk("hold_row", row_out, prev_row);
        chk("hold_idx", row_idx, prev_idx);
        chk("hold_no_rd", mem_rd_en, 0);
      end
      if (mem_rd_en) begin
        chk("mem_addr", mem_addr, 128'(exp_addr(x, y, nrd)));
        nrd++;
      end
      if (done) begin
        got_done = 1;
        chk("rows_at_done", nrows, NUM_ROWS);
        chk("busy_at_done", busy, 0);
        if (timing) chk("done_cycle", c, 76);
      end else if (nrows < NUM_ROWS) begin
        chk("busy", busy, 1);
      end
      hold = row_valid && !row_ready;
      prev_row = row_out;
      prev_idx = row_idx;
      if (row_valid && row_ready) begin
        chk("row_idx", row_idx, nrows);
        chk("row_out", row_out, exp_row(x, y, nrows));
        nrows++;
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    chk("reads_total", nrd, 3 * NUM_ROWS);
  endtask

  task automatic reset_mid_fetch(input int x, input int y);
    bit found = 0;
    @(posedge clk); #1;
    x0 = XW'(x); y0 = YW'(y); start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (row_idx == 4'd6 && mem_rd_en) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("reach_row6", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_row_out", row_out, 0);
    chk("rst_valid", row_valid, 0);
    chk("rst_idx", row_idx, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_ready = 1'b0; x0 = '0; y0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_rd_en", mem_rd_en, 0);
    chk("init_addr", mem_addr, 0);
    chk("init_row_out", row_out, 0);
    chk("init_valid", row_valid, 0);
    chk("init_idx", row_idx, 0);
    rst = 1'b0;

    run_block(3, 3, 0, 1);
    run_block(8, 3, 0, 0);
    run_block(5, 7, 3, 0);
    reset_mid_fetch(11, 5);
    run_block(3, 3, 0, 0);
    run_block(10, 4, 2, 0);
    for (int n = 0; n < 4; n++)
      run_block($urandom_range(3, 20), $urandom_range(3, 20), 1, 0);
`ifdef REF_ROW_FETCHER_EDGE_PAD_EN
    run_block(0, 0, 0, 0);
    run_block(30, 60, 0, 0);
    for (int n = 0; n < 3; n++)
      run_block($urandom_range(0, 40), $urandom_range(0, 63), 1, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ref_row_fetcher.md
Name: ref_row_fetcher

Overview:
- Upstream feeder for the subpixel interpolation datapath. Given a block origin (x0, y0), it reads the (8+7)x(8+7) integer-pixel reference window from word-wide frame memory.
- It emits the window one 15-pixel row per transfer over a valid/ready handshake. Each 120-bit row is exactly the in_row format the interpolator's input shift register loads.
- Pixel 0 of a row is at bits [7:0], and pixels ascend toward the MSB.

Parameters:
PIX_W, 8, bits per pixel
ROW_PIX, 15, pixels per output row (8 + 7 filter taps)
NUM_ROWS, 15, rows per block window
FRAME_W_WORDS, 240, frame width in 64-bit memory words (1920 px)
FRAME_H, 1080, frame height in rows (used only with EDGE_PAD_EN)
ADDR_W, 18, memory word address width
X_W, 11, width of x0
Y_W, 11, width of y0

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a block fetch; sampled only in IDLE
x0  in  X_W  block origin column (integer pixel)
y0  in  Y_W  block origin row
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after final row handshake
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  word address = row*FRAME_W_WORDS + word column
mem_rdata  in  64  read data, valid exactly 1 cycle after mem_rd_en
row_out  out  ROW_PIX*PIX_W  assembled row, 120 bits at default
row_valid  out  1  row_out holds a valid row
row_ready  in  1  consumer accepts the row
row_idx  out  4  index 0..NUM_ROWS-1 of the row on row_out

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, row_out=0, row_valid=0, row_idx=0; state=IDLE. Reset mid-operation aborts the fetch immediately; read data returned after reset is ignored.
- Window geometry: xs = x0-3, ys = y0-3, both signed. Row r reads frame line ys+r. Word base wb = xs>>>3 and shift s = xs[2:0].
- Three words are always read per row, at wb, wb+1 and wb+2. row_out = ({w2,w1,w0} >> (8*s))[119:0].
- Latches x0/y0 on start.
- FSM:
  - IDLE: on start, go to REQ with k=0 and r=0.
  - REQ: drive mem_rd_en=1 with the address for word k; k advances 0->1->2. After k=2, go to LAST.
  - LAST: capture the k=2 data and register the assembled row into row_out. Go to OUT.
  - OUT: row_valid=1. On row_valid&&row_ready: if r==NUM_ROWS-1, go to IDLE with done=1 next cycle; otherwise r++ and go to REQ.
- Words for k=0 and k=1 are captured in the cycle after their strobe.
- Latency: start in cycle T gives mem_rd_en in T+1..T+3 and row_valid at T+5. With row_ready held high, rows are spaced 5 cycles apart. A full block takes 75 cycles from start to the last handshake.
- row_out and row_idx stay stable while row_valid=1 and row_ready=0. row_valid is never withdrawn without a handshake.
- start while busy is ignored. start and the final handshake in the same cycle: start is ignored, because it is sampled only in IDLE.
- done is asserted one cycle after the last handshake, coincident with busy=0.

Optional Feature:
- Macro: REF_ROW_FETCHER_EDGE_PAD_EN.
- Defined:
  - Line index is clamped to [0, FRAME_H-1], and word indices are clamped to [0, FRAME_W_WORDS-1].
  - Each output pixel at absolute column xs+i < 0 takes pixel column 0. Each pixel at column > 8*FRAME_W_WORDS-1 takes the last column (HEVC edge replication).
  - Timing is unchanged.
- Undefined:
  - No clamping logic.
  - The caller guarantees x0>=3, y0>=3, x0+11 <= 8*FRAME_W_WORDS-1 and y0+11 < frame height.
  - Out-of-range origins produce unspecified pixel data, but the handshake and timing behaviour is unchanged.

Decomposition:
- Shared package: PIX_W, ROW_PIX, NUM_ROWS, the FSM state encoding (IDLE, REQ, LAST, OUT) and the filter-tap margin constant 3.
- One sub-module, row_aligner: combinational 192->120 bit funnel shifter by s. In EDGE_PAD_EN builds it also does the per-pixel edge-replication muxing.

Test Plan:
- Memory model: FRAME_W_WORDS=4, pixel(x,y) = (x + 32*y) & 0xFF. Set x0=3, y0=3, row_ready=1, then start:
  - first mem_addr=0, 1, 2 on T+1..T+3; row_valid at T+5;
  - row 0 bytes are 0x00..0x0E, LSB first;
  - row 14 bytes are 0x1C0..0x1CE & 0xFF;
  - done pulses at T+76.
- Unaligned: x0=8, y0=3. xs=5, s=5, words 0..2; row 0 pixels are 0x05..0x13.
- Backpressure: row_ready=0 for 10 cycles at row 2. row_out, row_idx=2 and row_valid stay constant, with no mem_rd_en; resuming ready completes normally.
- Reset mid-fetch: assert rst during REQ of row 6. Next cycle all outputs are 0 and state is IDLE; a fresh start fetches row 0 correctly.
- start pulsed while busy: ignored, and exactly 15 rows are delivered.
- EDGE_PAD_EN, x0=0, y0=0: row 0 pixels are 0,0,0,0,1,...,11. Rows 0..3 all equal line 0, and no mem_addr is negative.
